// File: rtl/control_unit.sv
// Multicycle RV32I control FSM: sequences PC, IR, regfile, ALU and the
// single-port memory bus with one Moore state per cycle.
module control_unit #(
    parameter logic [3:0] BOOT_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] instruction_opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       lorD,
    output logic       memory_read,
    output logic       memory_write,
    output logic [1:0] memory_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_immediate,
    output logic       pc_source,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_JALR_PC  = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_AUIPC    = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_decode_next;
    logic       w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode dispatch used only while in DECODE.
    always_comb begin
        w_decode_next = S_FETCH;
        w_legal       = 1'b1;
        case (instruction_opcode)
            OP_LOAD:   w_decode_next = S_MEMADR;
            OP_STORE:  w_decode_next = S_MEMADR;
            OP_REG:    w_decode_next = S_EXECUTER;
            OP_IMM:    w_decode_next = S_EXECUTEI;
            OP_BRANCH: w_decode_next = S_BRANCH;
            OP_JAL:    w_decode_next = S_JAL;
            OP_JALR:   w_decode_next = S_JALR;
            OP_LUI:    w_decode_next = S_LUI;
            OP_AUIPC:  w_decode_next = S_AUIPC;
            default: begin
                w_decode_next = S_FETCH;
                w_legal       = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE:   w_next = w_decode_next;
            S_MEMADR: begin
                if (instruction_opcode == OP_LOAD) begin
                    w_next = S_MEMREAD;
                end else if (instruction_opcode == OP_STORE) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JALR:     w_next = S_JALR_PC;
            S_LUI:      w_next = S_ALUWB;
            S_AUIPC:    w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        lorD          = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        memory_to_reg = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        is_immediate  = 1'b0;
        pc_source     = 1'b0;
        illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                memory_read = 1'b1;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                alu_src_b   = 2'b01;
            end
            S_DECODE: begin
                alu_src_a     = 2'b10;
                alu_src_b     = 2'b10;
                illegal_instr = !w_legal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                memory_read = 1'b1;
                lorD        = 1'b1;
            end
            S_MEMWB: begin
                reg_write     = 1'b1;
                memory_to_reg = 2'b01;
            end
            S_MEMWRITE: begin
                memory_write = 1'b1;
                lorD         = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                alu_op       = 2'b10;
                is_immediate = 1'b1;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            S_JAL, S_JALR_PC: begin
                // PC already holds old_pc+4, so it is the link value.
                pc_write      = 1'b1;
                pc_source     = 1'b1;
                reg_write     = 1'b1;
                memory_to_reg = 2'b10;
            end
            S_JALR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
            end
            S_AUIPC: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    assign state_o = r_state;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multicycle RV32I control FSM that sequences the shared core datapath: PC, IR, register file, ALU, ALUOut/MDR registers and the single memory bus. It decodes the 7-bit opcode from the IR and drives every datapath enable and mux select, one state per cycle. The memory interface has a single port with one-cycle latency and no wait states, so the block has no ack input.

Parameters:
BOOT_STATE, 4'd0, state entered on reset (FETCH). Not intended to be overridden.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instruction_opcode  input  7  IR[6:0]; valid from DECODE onward
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if datapath branch-taken flag is set
ir_write  output  1  IR load from memory data; datapath also captures old_pc on this strobe
lorD  output  1  memory address select: 0=PC, 1=ALUOut
memory_read  output  1  bus read strobe
memory_write  output  1  bus write strobe
memory_to_reg  output  2  regfile write-data select: 00=ALUOut, 01=MDR, 10=PC
reg_write  output  1  regfile write enable
alu_src_a  output  2  ALU A select: 00=PC, 01=rs1 reg, 10=old_pc, 11=zero
alu_src_b  output  2  ALU B select: 00=rs2 reg, 01=const 4, 10=immediate
alu_op  output  2  00=add, 01=branch compare (funct3), 10=funct decode
is_immediate  output  1  I-type ALU: ignore funct7 except for SRAI
pc_source  output  1  PC input select: 0=ALU result, 1=ALUOut
illegal_instr  output  1  one-cycle pulse in DECODE on an unknown opcode
state_o  output  4  current state, for debug and verification

Behaviour:
- State register: 4 bits, asynchronous reset to FETCH. Outputs are pure Moore combinational decode of the state. Any output not listed for a state is 0.
- Reset values (the FETCH outputs): memory_read=1, ir_write=1, pc_write=1, alu_src_b=01. Every other output is 0, and state_o=0.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately. The partial instruction is abandoned and no register or memory write occurs after the reset edge.
- State encodings and outputs:
  - 0 FETCH: memory_read, ir_write, lorD=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0, pc_write. Next: DECODE.
  - 1 DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (ALUOut <= old_pc+imm).
  - 2 MEMADR: alu_src_a=01, alu_src_b=10, alu_op=00. Next: LW -> MEMREAD, SW -> MEMWRITE.
  - 3 MEMREAD: memory_read, lorD=1. Next: MEMWB.
  - 4 MEMWB: reg_write, memory_to_reg=01. Next: FETCH.
  - 5 MEMWRITE: memory_write, lorD=1. Next: FETCH.
  - 6 EXECUTER: alu_src_a=01, alu_src_b=00, alu_op=10. Next: ALUWB.
  - 7 EXECUTEI: alu_src_a=01, alu_src_b=10, alu_op=10, is_immediate. Next: ALUWB.
  - 8 ALUWB: reg_write, memory_to_reg=00. Next: FETCH.
  - 9 BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=1. Next: FETCH.
  - 10 JAL: pc_write, pc_source=1, reg_write, memory_to_reg=10. Next: FETCH.
  - 11 JALR: alu_src_a=01, alu_src_b=10, alu_op=00. Next: JALR_PC.
  - 12 JALR_PC: pc_write, pc_source=1, reg_write, memory_to_reg=10. Next: FETCH. The datapath clears target bit 0.
  - 13 LUI: alu_src_a=11, alu_src_b=10, alu_op=00. Next: ALUWB.
  - 14 AUIPC: alu_src_a=10, alu_src_b=10, alu_op=00. Next: ALUWB.
  - 15 is unused and returns to FETCH with all outputs 0.
- DECODE transitions by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other value -> FETCH, with illegal_instr=1 for that DECODE cycle only
- MEMADR with an opcode other than LW or SW (only possible through an IR glitch) -> FETCH.
- Instruction cycle counts: LW 5; SW, R, I, JALR, LUI and AUIPC 4; BRANCH and JAL 3.
- memory_read and memory_write are never asserted together.
- In JAL and JALR_PC, PC already holds old_pc+4 when the link value is written, so rd receives the return address.

Test Plan:
- Release reset, opcode=0110011 -> state_o sequence 0,1,6,8,0; reg_write=1 only in cycle 4; pc_write=1 only in cycle 1.
- opcode=0000011 -> states 0,1,2,3,4,0; memory_read=1 with lorD=1 in state 3; memory_to_reg=01 with reg_write=1 in state 4.
- opcode=0100011 -> states 0,1,2,5,0; memory_write=1 and lorD=1 only in state 5; reg_write stays 0 throughout.
- opcode=1100011, then 1101111, then 1100111 -> BRANCH: pc_write_cond=1 with pc_source=1 in state 9. JAL: pc_write, reg_write and memory_to_reg=10 in state 10. JALR: states 11,12, with pc_source=1 in state 12.
- opcode=1111111 -> illegal_instr=1 in DECODE only, next state FETCH, no reg_write or memory_write asserted.
- Assert rst_n=0 asynchronously while in MEMREAD -> state_o=0 before the next clock edge; outputs take the FETCH values; the next instruction is fetched normally after release.
